// File: rtl/rv32i_axil_sysctl.sv
// rv32i_axil_sysctl: AXI4-Lite system-control slave for the core data bus.
// Holds two scratch registers, a 64-bit cycle counter with a tear-free
// high-word shadow, a sticky halt/result register and a status word.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   s_axi_aw*/w*/b*          AXI4-Lite write address, data and response
//   s_axi_ar*/r*             AXI4-Lite read address and data
//   halt_o, halt_code_o      sticky halt flag and the first HALT word written
//
// Register map (addr[4:2]):
//   0 SCRATCH0, 1 SCRATCH1, 2 CYCLE_LO, 3 CYCLE_HI (shadow),
//   4 HALT, 5 STATUS, 6-7 unmapped (SLVERR)
module rv32i_axil_sysctl #(
    parameter int          ADDR_W      = 12,
    parameter logic [31:0] SCRATCH_RST = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic [2:0]        s_axi_awprot,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic [2:0]        s_axi_arprot,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic              halt_o,
    output logic [31:0]       halt_code_o
);

    typedef enum logic {W_COLLECT, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_RESP} r_state_e;

    w_state_e    r_wstate;
    r_state_e    r_rstate;

    logic        r_awready;
    logic        r_wready;
    logic        r_bvalid;
    logic [1:0]  r_bresp;
    logic        r_aw_got;
    logic        r_w_got;
    logic [2:0]  r_awidx;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;

    logic        r_arready;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;

    logic [31:0] r_scratch0;
    logic [31:0] r_scratch1;
    logic [63:0] r_cnt;
    logic [31:0] r_shadow;
    logic        r_halt;
    logic [31:0] r_code;

    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_aw_have;
    logic        w_w_have;
    logic        w_commit;
    logic [2:0]  w_widx;
    logic [31:0] w_wdat;
    logic [3:0]  w_wstb;
    logic        w_ar_hs;
    logic [2:0]  w_ridx;
    logic [31:0] w_rdata;
    logic [1:0]  w_rresp;
    logic        w_unused;

    assign w_unused = ^{s_axi_awprot, s_axi_arprot,
                        s_axi_awaddr, s_axi_araddr};

    function automatic logic [31:0] f_merge(
        input logic [31:0] old,
        input logic [31:0] d,
        input logic [3:0]  s
    );
        logic [31:0] v;
        v = old;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) v[b*8 +: 8] = d[b*8 +: 8];
        end
        return v;
    endfunction

    // AW and W may arrive in either order; whichever is missing is taken
    // straight from the bus so the commit happens on the completing edge.
    assign w_aw_hs   = s_axi_awvalid & r_awready;
    assign w_w_hs    = s_axi_wvalid & r_wready;
    assign w_aw_have = r_aw_got | w_aw_hs;
    assign w_w_have  = r_w_got | w_w_hs;
    assign w_commit  = (r_wstate == W_COLLECT) & w_aw_have & w_w_have;
    assign w_widx    = r_aw_got ? r_awidx : s_axi_awaddr[4:2];
    assign w_wdat    = r_w_got ? r_wdata : s_axi_wdata;
    assign w_wstb    = r_w_got ? r_wstrb : s_axi_wstrb;

    assign w_ar_hs   = s_axi_arvalid & r_arready;
    assign w_ridx    = s_axi_araddr[4:2];

    // Write channel FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wstate  <= W_COLLECT;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
            r_aw_got  <= 1'b0;
            r_w_got   <= 1'b0;
            r_awidx   <= 3'd0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
        end else begin
            case (r_wstate)
                W_COLLECT: begin
                    if (w_commit) begin
                        r_wstate  <= W_RESP;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_aw_got  <= 1'b0;
                        r_w_got   <= 1'b0;
                        r_bvalid  <= 1'b1;
                        r_bresp   <= (w_widx[2:1] == 2'b11) ? 2'b10 : 2'b00;
                    end else begin
                        if (w_aw_hs) begin
                            r_aw_got  <= 1'b1;
                            r_awready <= 1'b0;
                            r_awidx   <= s_axi_awaddr[4:2];
                        end
                        if (w_w_hs) begin
                            r_w_got  <= 1'b1;
                            r_wready <= 1'b0;
                            r_wdata  <= s_axi_wdata;
                            r_wstrb  <= s_axi_wstrb;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        r_wstate  <= W_COLLECT;
                        r_bvalid  <= 1'b0;
                        r_bresp   <= 2'b00;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Read mux sees pre-write register values, so a read and a write
    // committing on the same edge return the old contents.
    always_comb begin
        w_rdata = 32'd0;
        w_rresp = 2'b00;
        case (w_ridx)
            3'd0:    w_rdata = r_scratch0;
            3'd1:    w_rdata = r_scratch1;
            3'd2:    w_rdata = r_cnt[31:0];
            3'd3:    w_rdata = r_shadow;
            3'd4:    w_rdata = r_code;
            3'd5:    w_rdata = {31'd0, r_halt};
            default: w_rresp = 2'b10;
        endcase
    end

    // Read channel FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rdata   <= 32'd0;
            r_rresp   <= 2'b00;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rstate  <= R_RESP;
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rdata   <= w_rdata;
                        r_rresp   <= w_rresp;
                    end
                end
                R_RESP: begin
                    if (s_axi_rready) begin
                        r_rstate  <= R_IDLE;
                        r_arready <= 1'b1;
                        r_rvalid  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Register file, counter and halt state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scratch0 <= SCRATCH_RST;
            r_scratch1 <= SCRATCH_RST;
            r_cnt      <= 64'd0;
            r_shadow   <= 32'd0;
            r_halt     <= 1'b0;
            r_code     <= 32'd0;
        end else begin
            if (!r_halt) r_cnt <= r_cnt + 64'd1;
            if (w_commit) begin
                case (w_widx)
                    3'd0: r_scratch0 <= f_merge(r_scratch0, w_wdat, w_wstb);
                    3'd1: r_scratch1 <= f_merge(r_scratch1, w_wdat, w_wstb);
                    3'd4: begin
                        if (w_wstb == 4'hF && !r_halt) begin
                            r_halt <= 1'b1;
                            r_code <= w_wdat;
                        end
                    end
                    default: ;
                endcase
            end
            // Latch the high word with the low-word read for tear-free pairs
            if (w_ar_hs && w_ridx == 3'd2) r_shadow <= r_cnt[63:32];
        end
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;
    assign halt_o        = r_halt;
    assign halt_code_o   = r_code;

endmodule

// File: tb/tb_rv32i_axil_sysctl.sv
// tb_rv32i_axil_sysctl: self-checking bench for rv32i_axil_sysctl.
// Drives AXI4-Lite transactions against a register-level reference model.
module tb_rv32i_axil_sysctl;

    localparam logic [31:0] RST_VAL = 32'hA5A5_0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [11:0] araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        halt;
    logic [31:0] halt_code;

    int tests = 0;
    int failed = 0;

    // Reference model state
    logic [31:0] m_scr [2];
    logic        m_halt = 1'b0;
    logic [31:0] m_code = '0;
    logic [31:0] m_shadow = '0;
    logic [63:0] tb_cnt;

    rv32i_axil_sysctl #(
        .ADDR_W(12),
        .SCRATCH_RST(RST_VAL)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(awaddr), .s_axi_awprot(awprot),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(arprot),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .halt_o(halt), .halt_code_o(halt_code)
    );

    always #5 clk = ~clk;

    // Cycles elapsed since reset release, paused while the model is halted
    always @(posedge clk or posedge rst) begin
        if (rst) tb_cnt <= 64'd0;
        else if (!m_halt) tb_cnt <= tb_cnt + 64'd1;
    end

    task automatic model_reset();
        m_scr[0] = RST_VAL;
        m_scr[1] = RST_VAL;
        m_halt = 1'b0;
        m_code = '0;
        m_shadow = '0;
    endtask

    task automatic model_write(input logic [11:0] a, input logic [31:0] d,
                               input logic [3:0] s, output logic [1:0] r);
        int idx;
        idx = int'(a[4:2]);
        r = (idx >= 6) ? 2'b10 : 2'b00;
        if (idx < 2) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) m_scr[idx][b*8 +: 8] = d[b*8 +: 8];
        end else if (idx == 4 && s == 4'hF && !m_halt) begin
            m_halt = 1'b1;
            m_code = d;
        end
    endtask

    task automatic model_read(input logic [11:0] a, input logic [63:0] snap,
                              output logic [31:0] d, output logic [1:0] r);
        int idx;
        idx = int'(a[4:2]);
        d = '0;
        r = 2'b00;
        if (idx < 2) d = m_scr[idx];
        else if (idx == 2) begin d = snap[31:0]; m_shadow = snap[63:32]; end
        else if (idx == 3) d = m_shadow;
        else if (idx == 4) d = m_code;
        else if (idx == 5) d = {31'd0, m_halt};
        else r = 2'b10;
    endtask

    // Full write; gap = cycles between AW and W handshakes, hold = bready stall
    task automatic axi_write(input logic [11:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int gap, input int hold,
                             output logic [1:0] resp, output logic [1:0] eresp,
                             output int lat, output bit ok);
        ok = 1'b1;
        @(negedge clk);
        if (!awready || !wready) ok = 1'b0;
        awaddr = a;
        awvalid = 1'b1;
        if (gap == 0) begin wdata = d; wstrb = s; wvalid = 1'b1; end
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0;
        if (gap > 0) begin
            if (awready || !wready || bvalid) ok = 1'b0;
            repeat (gap - 1) @(negedge clk);
            wdata = d; wstrb = s; wvalid = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        wvalid = 1'b0;
        model_write(a, d, s, eresp);
        lat = 1;
        while (!bvalid && lat < 20) begin @(negedge clk); lat++; end
        resp = bresp;
        repeat (hold) begin
            if (!bvalid || bresp !== resp || awready || wready) ok = 1'b0;
            @(negedge clk);
        end
        bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bready = 1'b0;
        if (bvalid || !awready || !wready) ok = 1'b0;
    endtask

    task automatic axi_read(input logic [11:0] a, input int hold,
                            output logic [31:0] data, output logic [1:0] resp,
                            output logic [31:0] edata, output logic [1:0] eresp,
                            output int lat, output bit ok);
        ok = 1'b1;
        @(negedge clk);
        if (!arready) ok = 1'b0;
        araddr = a;
        arvalid = 1'b1;
        model_read(a, tb_cnt, edata, eresp);
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        lat = 1;
        while (!rvalid && lat < 20) begin @(negedge clk); lat++; end
        data = rdata;
        resp = rresp;
        repeat (hold) begin
            if (!rvalid || rdata !== data || rresp !== resp || arready) ok = 1'b0;
            @(negedge clk);
        end
        rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rready = 1'b0;
        if (rvalid || !arready) ok = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d, ed, d1;
        logic [1:0]  r, er;
        int          lat;
        bit          ok;
        model_reset();
        repeat (2) @(negedge clk);
        tests++;
        if ({awready, wready, arready, bvalid, rvalid, halt} !== 6'b111000) begin
            failed++;
            $display("FAIL reset_ctrl got %b exp 111000",
                     {awready, wready, arready, bvalid, rvalid, halt});
        end
        tests++;
        if ({rdata, halt_code, bresp, rresp} !== 68'd0) begin
            failed++;
            $display("FAIL reset_data got rdata=%h code=%h bresp=%b rresp=%b exp 0",
                     rdata, halt_code, bresp, rresp);
        end
        rst = 1'b0;
        axi_read(12'h000, 0, d, r, ed, er, lat, ok);
        tests++;
        if (d !== RST_VAL || r !== 2'b00 || lat != 1 || !ok) begin
            failed++;
            $display("FAIL reset_scratch0 got %h/%b lat %0d ok %0d exp %h/00 lat 1",
                     d, r, lat, ok, RST_VAL);
        end
        axi_read(12'h008, 0, d1, r, ed, er, lat, ok);
        tests++;
        if (d1 !== ed || d1 == 32'd0 || r !== 2'b00) begin
            failed++;
            $display("FAIL cycle_lo_first got %h exp %h (nonzero)", d1, ed);
        end
        axi_read(12'h008, 0, d, r, ed, er, lat, ok);
        tests++;
        if (d !== ed || d <= d1) begin
            failed++;
            $display("FAIL cycle_lo_incr got %h exp %h (> %h)", d, ed, d1);
        end
    endtask

    task automatic test_write_order();
        logic [31:0] d, ed;
        logic [1:0]  r, er;
        int          lat;
        bit          ok;
        axi_write(12'h004, 32'hDEADBEEF, 4'hF, 3, 0, r, er, lat, ok);
        tests++;
        if (r !== 2'b00 || lat != 1 || !ok) begin
            failed++;
            $display("FAIL aw_before_w got resp %b lat %0d ok %0d exp 00 lat 1 ok 1",
                     r, lat, ok);
        end
        axi_read(12'h004, 0, d, r, ed, er, lat, ok);
        tests++;
        if (d !== 32'hDEADBEEF) begin
            failed++;
            $display("FAIL scratch1_rb got %h exp deadbeef", d);
        end
        axi_write(12'h004, 32'h0000_5500, 4'b0010, 0, 0, r, er, lat, ok);
        axi_read(12'h004, 0, d, r, ed, er, lat, ok);
        tests++;
        if (d !== 32'hDEAD55EF || d !== ed) begin
            failed++;
            $display("FAIL strobe_merge got %h exp dead55ef", d);
        end
    endtask

    task automatic test_random();
        logic [31:0] d, ed, dat;
        logic [1:0]  r, er;
        logic [11:0] a;
        logic [2:0]  idx;
        logic [3:0]  s;
        int          lat;
        bit          ok;
        int          bad;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            a = 12'($urandom);
            idx = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) begin
                if (idx == 3'd4) idx = 3'd0;
                a[4:2] = idx;
                dat = $urandom;
                s = 4'($urandom);
                axi_write(a, dat, s, $urandom_range(0, 3), $urandom_range(0, 2),
                          r, er, lat, ok);
                if (r !== er || lat != 1 || !ok) begin
                    bad++;
                    $display("FAIL rand_write a=%h got %b lat %0d ok %0d exp %b",
                             a, r, lat, ok, er);
                end
            end else begin
                a[4:2] = idx;
                axi_read(a, $urandom_range(0, 2), d, r, ed, er, lat, ok);
                if (d !== ed || r !== er || lat != 1 || !ok) begin
                    bad++;
                    $display("FAIL rand_read a=%h got %h/%b lat %0d ok %0d exp %h/%b",
                             a, d, r, lat, ok, ed, er);
                end
            end
        end
        tests++;
        if (bad != 0) failed++;
    endtask

    task automatic test_backpressure();
        logic [31:0] d, ed;
        logic [1:0]  r, er;
        int          lat;
        bit          ok;
        axi_write(12'h000, 32'h1357_9BDF, 4'hF, 0, 10, r, er, lat, ok);
        tests++;
        if (r !== 2'b00 || lat != 1 || !ok) begin
            failed++;
            $display("FAIL bready_stall got resp %b lat %0d ok %0d exp 00 lat 1 ok 1",
                     r, lat, ok);
        end
        axi_read(12'h000, 10, d, r, ed, er, lat, ok);
        tests++;
        if (d !== ed || d !== 32'h1357_9BDF || !ok) begin
            failed++;
            $display("FAIL rready_stall got %h ok %0d exp %h ok 1", d, ok, ed);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] d, ed;
        logic [1:0]  r, er;
        int          lat;
        bit          ok;
        axi_write(12'h018, 32'hFFFF_FFFF, 4'hF, 1, 0, r, er, lat, ok);
        tests++;
        if (r !== 2'b10) begin
            failed++;
            $display("FAIL unmapped_write got %b exp 10", r);
        end
        axi_read(12'h018, 0, d, r, ed, er, lat, ok);
        tests++;
        if (d !== 32'd0 || r !== 2'b10) begin
            failed++;
            $display("FAIL unmapped_read got %h/%b exp 0/10", d, r);
        end
        axi_read(12'h000, 0, d, r, ed, er, lat, ok);
        tests++;
        if (d !== ed) begin
            failed++;
            $display("FAIL unmapped_side got %h exp %h", d, ed);
        end
        axi_write(12'h008, 32'h1234_5678, 4'hF, 0, 0, r, er, lat, ok);
        tests++;
        if (r !== 2'b00) begin
            failed++;
            $display("FAIL ro_write_resp got %b exp 00", r);
        end
        axi_read(12'h008, 0, d, r, ed, er, lat, ok);
        tests++;
        if (d !== ed) begin
            failed++;
            $display("FAIL ro_write_cnt got %h exp %h", d, ed);
        end
    endtask

    task automatic test_cycle_pair();
        logic [31:0] lo, hi, elo, ehi;
        logic [1:0]  r, er;
        int          lat;
        bit          ok;
        axi_read(12'h008, 0, lo, r, elo, er, lat, ok);
        repeat (5) @(negedge clk);
        axi_read(12'h00C, 0, hi, r, ehi, er, lat, ok);
        tests++;
        if (lo !== elo || hi !== ehi) begin
            failed++;
            $display("FAIL cycle_pair got %h_%h exp %h_%h", hi, lo, ehi, elo);
        end
    endtask

    task automatic test_halt();
        logic [31:0] d, ed, d1;
        logic [1:0]  r, er;
        int          lat;
        bit          ok;
        axi_write(12'h010, 32'd5, 4'h7, 0, 0, r, er, lat, ok);
        tests++;
        if (halt !== 1'b0 || halt_code !== 32'd0 || r !== 2'b00) begin
            failed++;
            $display("FAIL halt_partial got halt %b code %h resp %b exp 0 0 00",
                     halt, halt_code, r);
        end
        axi_write(12'h010, 32'd1, 4'hF, 0, 0, r, er, lat, ok);
        tests++;
        if (halt !== 1'b1 || halt_code !== 32'd1 || lat != 1 || r !== 2'b00) begin
            failed++;
            $display("FAIL halt_set got halt %b code %h lat %0d exp 1 1 lat 1",
                     halt, halt_code, lat);
        end
        axi_write(12'h010, 32'd7, 4'hF, 2, 0, r, er, lat, ok);
        tests++;
        if (halt_code !== 32'd1 || r !== 2'b00) begin
            failed++;
            $display("FAIL halt_sticky got code %h resp %b exp 1 00", halt_code, r);
        end
        axi_read(12'h008, 0, d1, r, ed, er, lat, ok);
        repeat (4) @(negedge clk);
        axi_read(12'h008, 0, d, r, ed, er, lat, ok);
        tests++;
        if (d !== d1 || d !== ed) begin
            failed++;
            $display("FAIL cnt_frozen got %h then %h exp %h", d1, d, ed);
        end
        axi_read(12'h014, 0, d, r, ed, er, lat, ok);
        tests++;
        if (d !== 32'd1) begin
            failed++;
            $display("FAIL status got %h exp 1", d);
        end
        axi_read(12'h010, 0, d, r, ed, er, lat, ok);
        tests++;
        if (d !== 32'd1) begin
            failed++;
            $display("FAIL halt_read got %h exp 1", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d, ed;
        logic [1:0]  r, er;
        int          lat;
        bit          ok;
        int          n;
        @(negedge clk);
        awaddr = 12'h000; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        rst = 1'b1;
        model_reset();
        #1;
        tests++;
        if ({bvalid, awready, wready, halt} !== 4'b0110 || halt_code !== 32'd0) begin
            failed++;
            $display("FAIL reset_in_resp got %b code %h exp 0110 0",
                     {bvalid, awready, wready, halt}, halt_code);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        axi_read(12'h000, 0, d, r, ed, er, lat, ok);
        tests++;
        if (d !== RST_VAL) begin
            failed++;
            $display("FAIL reset_scratch got %h exp %h", d, RST_VAL);
        end
        axi_read(12'h008, 0, d, r, ed, er, lat, ok);
        tests++;
        if (d !== ed) begin
            failed++;
            $display("FAIL reset_cnt got %h exp %h", d, ed);
        end
    endtask

    initial begin
        test_reset();
        test_write_order();
        test_random();
        test_backpressure();
        test_unmapped();
        test_cycle_pair();
        test_halt();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
